// File: rtl/ofdm_tx_pkg.sv
// Shared types and helpers for the OFDM transmit chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: IQW default, {I, Q} sample type, read-FSM state encoding, clog2.
package ofdm_tx_pkg;

  localparam int IQW_DEF = 16;

  // One complex sample, I in the upper half, Q in the lower half.
  typedef struct packed {
    logic [IQW_DEF-1:0] i;
    logic [IQW_DEF-1:0] q;
  } sample_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PREFIX = 2'd1,
    RD_BODY   = 2'd2
  } rd_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ofdm_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Latency: read data appears on rdata_o one clock after re_i.
// Backpressure: none; the caller schedules reads and writes.
// Ports: clk_i; we_i/waddr_i/wdata_i write port; re_i/raddr_i/rdata_o read port.
module ofdm_sample_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: buffers one IFFT symbol per bank, emits last cp samples then the symbol.
// Latency: first prefix sample on STB_O two clocks after the last input sample is accepted.
// Backpressure: ACK_O low while the write bank is full; 2-entry output/skid holds data while ACK_I low.
// Ports: CLK_I/RST_I clock and async active-low reset; DAT_I/CYC_I/STB_I/WE_I/ACK_O upstream slave;
//        CP_LEN_I prefix length; DAT_O/CYC_O/STB_O/WE_O/ACK_I downstream master.
module ofdm_cp_insert
  import ofdm_tx_pkg::*;
#(
  parameter int NFFT   = 64,
  parameter int CP_MAX = 32,
  parameter int IQW    = IQW_DEF
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic [2*IQW-1:0]             DAT_I,
  input  logic                         CYC_I,
  input  logic                         STB_I,
  input  logic                         WE_I,
  output logic                         ACK_O,
  input  logic [clog2(CP_MAX+1)-1:0]   CP_LEN_I,
  output logic [2*IQW-1:0]             DAT_O,
  output logic                         CYC_O,
  output logic                         STB_O,
  output logic                         WE_O,
  input  logic                         ACK_I
);

  localparam int IW  = clog2(NFFT);
  localparam int CPW = clog2(CP_MAX+1);
  localparam int DW  = 2*IQW;
  localparam logic [IW-1:0] LAST_IDX = IW'(NFFT-1);

  // ---------------- write side ----------------
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    full_q, full_d;
  logic          wr_fire, wr_last;

  // Gated by reset so the slave never acknowledges while held in reset.
  assign ACK_O   = RST_I & CYC_I & STB_I & WE_I & ~full_q[wr_bank_q];
  assign wr_fire = ACK_O;
  assign wr_last = wr_fire & (wr_idx_q == LAST_IDX);

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (wr_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IW'(1);
      end
    end else if (!CYC_I) begin
      // Cycle abandoned mid-symbol: drop the partial data.
      wr_idx_d = '0;
    end
  end

  // ---------------- read issue FSM ----------------
  rd_state_e     state_q, state_d, cur_st, start_st;
  logic [IW-1:0] iss_idx_q, iss_idx_d, cur_idx, start_idx;
  logic          rd_bank_q, rd_bank_d;
  logic [CPW-1:0] cp_new;
  logic          iss_en, iss_last, issue_ok, pop;
  logic [1:0]    fill;

  // Output-side pipeline: RAM data register, output register, skid register.
  logic          rd_vld_q, rd_last_q;
  logic [DW-1:0] ram_rdata;
  logic          stb_q, stb_d, out_last_q, out_last_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          free_bank_q, free_fire;

  // Prefix length for the symbol about to start; the start index encodes it,
  // so it needs no separate register. cp = 0 wraps NFFT to index 0.
  assign cp_new    = (CP_LEN_I > CPW'(CP_MAX)) ? CPW'(CP_MAX) : CP_LEN_I;
  assign start_st  = (cp_new == '0) ? RD_BODY : RD_PREFIX;
  assign start_idx = IW'(NFFT - int'(cp_new));

  assign pop  = stb_q & ACK_I;
  assign fill = {1'b0, stb_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};
  // A read issued now lands one cycle later; it must find a free slot even if
  // the output stalls then, so issue only if at most one entry remains after this cycle.
  assign issue_ok = (fill <= ({1'b0, pop} + 2'd1));

  always_comb begin
    state_d   = state_q;
    iss_idx_d = iss_idx_q;
    rd_bank_d = rd_bank_q;
    iss_last  = 1'b0;
    cur_st    = state_q;
    cur_idx   = iss_idx_q;
    // IDLE issues the first read of a symbol itself, saving a cycle of latency.
    if (state_q == RD_IDLE) begin
      cur_st  = start_st;
      cur_idx = start_idx;
      iss_en  = full_q[rd_bank_q] & issue_ok;
    end else begin
      iss_en  = issue_ok;
    end
    if (iss_en) begin
      if (cur_idx != LAST_IDX) begin
        state_d   = cur_st;
        iss_idx_d = cur_idx + IW'(1);
      end else if (cur_st == RD_PREFIX) begin
        state_d   = RD_BODY;
        iss_idx_d = '0;
      end else begin
        iss_last  = 1'b1;
        rd_bank_d = ~rd_bank_q;
        if (full_q[~rd_bank_q]) begin
          state_d   = start_st;
          iss_idx_d = start_idx;
        end else begin
          state_d   = RD_IDLE;
          iss_idx_d = '0;
        end
      end
    end
  end

  ofdm_sample_ram #(.AW(IW+1), .DW(DW)) u_ram (
    .clk_i   (CLK_I),
    .we_i    (wr_fire),
    .waddr_i ({wr_bank_q, wr_idx_q}),
    .wdata_i (DAT_I),
    .re_i    (iss_en),
    .raddr_i ({rd_bank_q, cur_idx}),
    .rdata_o (ram_rdata)
  );

  // A bank is released only once its final sample has been taken downstream.
  assign free_fire = pop & out_last_q;

  always_comb begin
    full_d = full_q;
    if (free_fire) full_d[free_bank_q] = 1'b0;
    if (wr_last)   full_d[wr_bank_q]   = 1'b1;
  end

  always_comb begin
    stb_d       = stb_q;
    dat_d       = dat_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_d      = skid_q;
    skid_last_d = skid_last_q;
    if (!stb_q || pop) begin
      if (skid_vld_q) begin
        stb_d       = 1'b1;
        dat_d       = skid_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = rd_vld_q;
        skid_d      = ram_rdata;
        skid_last_d = rd_last_q;
      end else if (rd_vld_q) begin
        stb_d      = 1'b1;
        dat_d      = ram_rdata;
        out_last_d = rd_last_q;
      end else begin
        stb_d      = 1'b0;
        out_last_d = 1'b0;
      end
    end else if (rd_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_d      = ram_rdata;
      skid_last_d = rd_last_q;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      state_q     <= RD_IDLE;
      iss_idx_q   <= '0;
      rd_bank_q   <= 1'b0;
      free_bank_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      stb_q       <= 1'b0;
      dat_q       <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_q      <= '0;
      skid_last_q <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      state_q     <= state_d;
      iss_idx_q   <= iss_idx_d;
      rd_bank_q   <= rd_bank_d;
      if (free_fire) free_bank_q <= ~free_bank_q;
      rd_vld_q    <= iss_en;
      rd_last_q   <= iss_last;
      stb_q       <= stb_d;
      dat_q       <= dat_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_q      <= skid_d;
      skid_last_q <= skid_last_d;
    end
  end

  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;
  // Held through the pipeline drain so the cycle ends with the last sample.
  assign CYC_O = (state_q != RD_IDLE) | rd_vld_q | skid_vld_q | stb_q;

endmodule

// File: doc/ofdm_cp_insert.md
# ofdm_cp_insert

Parametrised cyclic-prefix inserter for the OFDM transmit chain, placed between the IFFT stage and the transmit output stage. It buffers one IFFT symbol of NFFT complex samples. It then streams the last CP samples of that symbol, followed by the full symbol, on a Wishbone-style master port. CP length is selectable per symbol at run time, and a ping-pong buffer lets a new symbol be written while the previous one is still being read out.

## Interface
- NFFT, 64: samples per OFDM symbol; power of two, 16..1024.
- CP_MAX, 32: largest prefix length supported; 0 < CP_MAX ≤ NFFT.
- IQW, 16: bits per I and per Q component; sample width is 2*IQW, packed as {I, Q}.
- CLK_I  in  1: single clock; all logic is rising-edge.
- RST_I  in  1: asynchronous, active-low reset.
- DAT_I  in  2*IQW: input sample.
- CYC_I, STB_I, WE_I  in  1 each: upstream Wishbone cycle, strobe and write-enable.
- ACK_O  out  1: input sample accepted.
- CP_LEN_I  in  clog2(CP_MAX+1): requested prefix length; sampled at the start of each symbol readout.
- DAT_O  out  2*IQW: output sample.
- CYC_O, STB_O, WE_O  out  1 each: downstream Wishbone cycle, strobe and write-enable.
- ACK_I  in  1: downstream accepted the sample.

## Operation
- Buffer: two banks of NFFT samples, each with a `full` flag. The write side and the read side each have their own bank pointer.
- Input transfer: occurs when CYC_I & STB_I & WE_I & ACK_O are all high.
  - ACK_O = CYC_I & STB_I & WE_I & ~full[wr_bank]. This is combinational and is the only combinational path.
- Write side: the sample goes to index wr_idx.
  - When the sample at wr_idx = NFFT-1 is accepted: set full[wr_bank], toggle wr_bank, clear wr_idx.
  - If CYC_I drops while 0 < wr_idx < NFFT, the partial symbol is discarded: wr_idx returns to 0 and the flag stays clear.
- Read FSM has three states: IDLE, PREFIX, BODY.
  - IDLE → PREFIX when full[rd_bank] is set. Latch cp = min(CP_LEN_I, CP_MAX).
  - If cp = 0, go directly to BODY.
  - PREFIX emits indices NFFT-cp .. NFFT-1, then moves to BODY.
  - BODY emits indices 0 .. NFFT-1.
  - After the last BODY sample is accepted: clear full[rd_bank] and toggle rd_bank.
  - Then go to PREFIX if the other bank is full (re-latching CP_LEN_I); otherwise go to IDLE.
- Output transfer: occurs when STB_O & ACK_I are both high. While STB_O is high and ACK_I is low, DAT_O must not change.
- WE_O = STB_O.
- CYC_O is high whenever the FSM is not in IDLE.
- Simultaneous events: in the same cycle the read side may free a bank while the write side fills the other bank; both actions take effect.
  - A bank freed by the read side accepts writes from the next cycle onward.
- Reset values: ACK_O = 0 (inputs idle), DAT_O = 0, STB_O = 0, CYC_O = 0, WE_O = 0. All flags, pointers and indices are 0; FSM is in IDLE.
- Reset asserted mid-operation clears everything immediately. No stale sample is emitted after release.

## Timing
- Latency: the read FSM is IDLE and the last sample of a symbol is accepted at edge t. STB_O rises carrying the first prefix sample after edge t+2.
- Throughput: with ACK_I held high, STB_O stays high for exactly NFFT+cp consecutive cycles per symbol.
  - There is no gap between symbols when the next bank is already full.
- RAM read is registered. A prefetch/skid register is required so that a one-cycle ACK_I toggle never inserts a bubble or repeats a sample.
- Steady state: the input sustains NFFT accepts per NFFT+cp output cycles. The remaining cycles are absorbed by ACK_O low while both banks are full.

## Structure
- Package ofdm_tx_pkg holds:
  - the IQW default and the sample typedef {I, Q};
  - the read-FSM state enum (IDLE, PREFIX, BODY);
  - a clog2 helper.
- Sub-module ofdm_sample_ram: simple dual-port RAM, 2*NFFT deep, 2*IQW wide, one write port, one registered read port. Address is {bank, index}.
- Top level holds the write control, the read FSM, the skid register and the handshake logic.

## Test plan
- **Ramp, single symbol.** Parameters NFFT=64, CP_MAX=32, CP_LEN_I=16. Input sample k = {k, -k} for k = 0..63, ACK_I = 1. Required response:
  - 80 outputs: k = 48..63, then k = 0..63;
  - STB_O contiguous;
  - first STB_O 2 cycles after the 64th ACK_O;
  - CYC_O falls after the last sample.
- **Three symbols back-to-back, continuous input.** Required response:
  - 240 contiguous output samples;
  - ACK_O low while both banks are full;
  - no sample lost or duplicated.
- **Random backpressure.** ACK_I driven high with 50% probability. Required response:
  - DAT_O stable whenever STB_O & ~ACK_I;
  - output sequence identical to the ramp test.
- **Per-symbol CP length.** CP_LEN_I = 16, 0, 63 on successive symbols. Required response: symbol lengths 80, 64, 96; 63 is clamped to 32.
- **Partial symbol discard.** CYC_I dropped after 20 samples, then a full symbol is sent. Required response:
  - the partial data is never output;
  - the next symbol is output exactly.
- **Reset mid-readout.** RST_I driven low during BODY. Required response:
  - STB_O, CYC_O and ACK_O go to 0 immediately, without waiting for a clock edge;
  - after release, a fresh symbol is output correctly.
